// File: rtl/pmp_pkg.sv
// Shared PMP types and helpers.
//   pmp_cfg_t : one pmpcfg byte {L, rsvd, A, X, W, R}
//   pmp_a_e   : address-matching mode
//   pmp_acc_e : access type carried with each check request
//   PRIV_M    : machine-mode privilege encoding
//   perm_bit  : R/W/X permission selected by an access type (0 for illegal types)
package pmp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_a_e;

  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } pmp_acc_e;

  typedef struct packed {
    logic       lock;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  localparam logic [1:0] PRIV_M = 2'd3;

  function automatic logic perm_bit(pmp_cfg_t cfg, logic [1:0] acc);
    logic p;
    p = 1'b0;
    case (acc)
      ACC_R:   p = cfg.r;
      ACC_W:   p = cfg.w;
      ACC_X:   p = cfg.x;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match of one PMP entry.
//   word_addr_i : PA[AddrWidth+1:2] being checked
//   cfg_i       : pmpcfg of this entry
//   addr_i      : pmpaddr of this entry
//   addr_prev_i : pmpaddr of the previous entry (0 for entry 0), TOR lower bound
//   match_o     : entry covers word_addr_i
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] word_addr_i,
  input  pmp_cfg_t             cfg_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] addr_prev_i,
  output logic                 match_o
);

  // addr ^ (addr + 1) sets the trailing ones plus the first zero above them; an
  // all-ones pmpaddr yields an all-zero mask, i.e. a match-everything region.
  logic [AddrWidth-1:0] napot_mask;
  assign napot_mask = ~(addr_i ^ (addr_i + 1'b1));

  always_comb begin
    match_o = 1'b0;
    unique case (cfg_i.a)
      OFF:   match_o = 1'b0;
      TOR:   match_o = (addr_prev_i < addr_i) && (word_addr_i >= addr_prev_i) &&
                       (word_addr_i < addr_i);
      NA4:   match_o = (word_addr_i == addr_i);
      NAPOT: match_o = ((word_addr_i & napot_mask) == (addr_i & napot_mask));
    endcase
  end

endmodule

// File: rtl/pmp_check_sched.sv
// Shared sequential PMP checker. Round-robin arbitrates REQ_NUM requesters onto
// one engine that scans one PMP entry per cycle and stops at the lowest match.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_vld/req_rdy    : per-requester request handshake (req_rdy one-hot)
//   req_addr/mode/acc  : byte PA, privilege, access type per requester
//   pmp_cfg/pmp_addr   : flattened CSR state; cfg_upd pulses on any CSR write
//   resp_*             : result channel (id, pass, matching entry, MSB=no match)
//   busy               : engine not idle
module pmp_check_sched
  import pmp_pkg::*;
#(
  parameter int unsigned ENTRY_NUM  = 16,
  parameter int unsigned REQ_NUM    = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned IdW  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int unsigned IdxW = $clog2(ENTRY_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQ_NUM-1:0]              req_vld,
  output logic [REQ_NUM-1:0]              req_rdy,
  input  logic [REQ_NUM*(ADDR_WIDTH+2)-1:0] req_addr,
  input  logic [REQ_NUM*2-1:0]            req_mode,
  input  logic [REQ_NUM*2-1:0]            req_acc,
  input  logic [ENTRY_NUM*8-1:0]          pmp_cfg,
  input  logic [ENTRY_NUM*ADDR_WIDTH-1:0] pmp_addr,
  input  logic                            cfg_upd,
  output logic                            resp_vld,
  input  logic                            resp_rdy,
  output logic [IdW-1:0]                  resp_id,
  output logic                            resp_pass,
  output logic [IdxW:0]                   resp_idx,
  output logic                            busy
);

  localparam int unsigned PaW = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_q, rr_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            acc_q, acc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  pass_q, pass_d;
  logic [IdxW:0]         ridx_q, ridx_d;

  // Round-robin: first valid requester at or after rr_q, wrapping.
  logic           gnt_found;
  logic [IdW-1:0] gnt_id;
  logic [IdW:0]   rr_sum;
  logic [IdW-1:0] rr_slot;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    rr_sum    = '0;
    rr_slot   = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      rr_sum = {1'b0, rr_q} + (IdW+1)'(i);
      if (rr_sum >= (IdW+1)'(REQ_NUM)) rr_sum = rr_sum - (IdW+1)'(REQ_NUM);
      rr_slot = rr_sum[IdW-1:0];
      if (!gnt_found && req_vld[rr_slot]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_slot;
      end
    end
  end

  // Gated by rst_n so no grant is advertised while the engine is held in reset.
  always_comb begin
    req_rdy = '0;
    if (state_q == StIdle && gnt_found && rst_n) req_rdy[gnt_id] = 1'b1;
  end

  // Entry currently under scan.
  pmp_cfg_t              cfg_cur;
  logic [ADDR_WIDTH-1:0] addr_cur, addr_prev;
  logic [IdxW-1:0]       idx_prev;
  logic                  hit, pass_hit, pass_miss;

  assign cfg_cur   = pmp_cfg_t'(pmp_cfg[idx_q*8 +: 8]);
  assign addr_cur  = pmp_addr[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign idx_prev  = idx_q - 1'b1;
  assign addr_prev = (idx_q == '0) ? '0 : pmp_addr[idx_prev*ADDR_WIDTH +: ADDR_WIDTH];

  pmp_entry_match #(
    .AddrWidth(ADDR_WIDTH)
  ) u_entry_match (
    .word_addr_i(addr_q),
    .cfg_i      (cfg_cur),
    .addr_i     (addr_cur),
    .addr_prev_i(addr_prev),
    .match_o    (hit)
  );

  // Access type 3 is illegal and always denied, even for M-mode.
  assign pass_hit  = (acc_q != 2'd3) &&
                     (((mode_q == PRIV_M) && !cfg_cur.lock) || perm_bit(cfg_cur, acc_q));
  assign pass_miss = (mode_q == PRIV_M) && (acc_q != 2'd3);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    ridx_d  = ridx_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          id_d    = gnt_id;
          addr_d  = req_addr[gnt_id*PaW + 2 +: ADDR_WIDTH];
          mode_d  = req_mode[gnt_id*2 +: 2];
          acc_d   = req_acc[gnt_id*2 +: 2];
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (cfg_upd) begin
          // CSRs changed under us: any result from this cycle is stale.
          idx_d = '0;
        end else if (hit) begin
          pass_d  = pass_hit;
          ridx_d  = {1'b0, idx_q};
          state_d = StResp;
        end else if (idx_q == IdxW'(ENTRY_NUM - 1)) begin
          pass_d  = pass_miss;
          ridx_d  = {1'b1, idx_q};
          state_d = StResp;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_rdy) begin
          state_d = StIdle;
          rr_d    = (id_q == IdW'(REQ_NUM - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      ridx_q  <= ridx_d;
    end
  end

  assign resp_vld  = (state_q == StResp);
  assign resp_id   = id_q;
  assign resp_pass = pass_q;
  assign resp_idx  = ridx_q;
  assign busy      = (state_q != StIdle);

endmodule
